// File: rtl/dff_rr_ctrl.sv
// rtl/dff_rr_ctrl.sv - round-robin sequencer sharing one sync clear/preset DFF register
// Optional feature macro: DFF_RR_CTRL_TOGGLE_EN (op 11 toggles instead of holding)
module dff_rr_ctrl #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [2*NREQ-1:0]     op,
   input  logic [WIDTH*NREQ-1:0] din,
   output logic [NREQ-1:0]       gnt,
   output logic                  busy,
   output logic [WIDTH-1:0]      q,
   output logic [WIDTH-1:0]      qb,
   output logic [7:0]            grant_cnt
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_CLEAR = 2'b01;
   localparam logic [1:0] OP_SET   = 2'b10;

   typedef enum logic [1:0] {IDLE, ISSUE, COMMIT} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IW-1:0]    r_ptr;
   logic [IW-1:0]    r_win;
   logic [1:0]       r_op;
   logic [WIDTH-1:0] r_din;
   logic [WIDTH-1:0] r_q;
   logic [7:0]       r_cnt;

   logic [IW-1:0]    w_win;
   logic [1:0]       w_op_sel;
   logic [WIDTH-1:0] w_din_sel;
   logic             w_any;
   int               w_dist;
   int               w_best;
   logic [WIDTH-1:0] w_d;
   logic             w_clr;
   logic             w_pre_n;

   // Winner is the requester with the smallest cyclic distance from r_ptr.
   always_comb begin
      w_win     = r_ptr;
      w_any     = |req;
      w_best    = NREQ;
      w_dist    = 0;
      w_op_sel  = '0;
      w_din_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (req[i]) begin
            w_dist = (i >= int'(r_ptr)) ? (i - int'(r_ptr)) : (i + NREQ - int'(r_ptr));
            if (w_dist < w_best) begin
               w_best = w_dist;
               w_win  = IW'(i);
            end
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (w_win == IW'(i)) begin
            w_op_sel  = op[2*i +: 2];
            w_din_sel = din[WIDTH*i +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_any) w_state_nxt = ISSUE;
         ISSUE:   w_state_nxt = COMMIT;
         COMMIT:  w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr <= '0;
         r_win <= '0;
         r_op  <= '0;
         r_din <= '0;
         r_cnt <= '0;
      end else begin
         if (r_state == IDLE && w_any) begin
            r_win <= w_win;
            r_op  <= w_op_sel;
            r_din <= w_din_sel;
         end
         if (r_state == COMMIT) begin
            r_cnt <= r_cnt + 8'd1;
            r_ptr <= (r_win == IW'(NREQ-1)) ? '0 : r_win + IW'(1);
         end
      end
   end

   // Register cell controls: D follows q except during ISSUE, so q moves only on that edge.
   always_comb begin
      w_d     = r_q;
      w_clr   = 1'b0;
      w_pre_n = 1'b1;
      if (r_state == ISSUE) begin
         case (r_op)
            OP_LOAD:  w_d     = r_din;
            OP_CLEAR: w_clr   = 1'b1;
            OP_SET:   w_pre_n = 1'b0;
            default: begin
`ifdef DFF_RR_CTRL_TOGGLE_EN
               w_d = ~r_q;
`else
               w_d = r_q;
`endif
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_q <= '0;
      end else if (w_clr) begin
         r_q <= '0;
      end else if (!w_pre_n) begin
         r_q <= '1;
      end else begin
         r_q <= w_d;
      end
   end

   always_comb begin
      gnt = '0;
      for (int i = 0; i < NREQ; i++) begin
         gnt[i] = (r_state == COMMIT) && (r_win == IW'(i));
      end
   end

   assign busy      = (r_state != IDLE);
   assign q         = r_q;
   assign qb        = ~r_q;
   assign grant_cnt = r_cnt;

endmodule

// File: tb/tb_dff_rr_ctrl.sv
// tb/tb_dff_rr_ctrl.sv - directed table-driven bench for dff_rr_ctrl
module tb_dff_rr_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [7:0] op;
   logic [31:0] din;
   logic [3:0] gnt;
   logic       busy;
   logic [7:0] q;
   logic [7:0] qb;
   logic [7:0] grant_cnt;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;

`ifdef DFF_RR_CTRL_TOGGLE_EN
   localparam logic [7:0] EXP_OP11 = 8'hF0;
`else
   localparam logic [7:0] EXP_OP11 = 8'h0F;
`endif

   typedef struct {
      int         idx;
      logic [1:0] opv;
      logic [7:0] dinv;
      logic [7:0] exp_q;
   } vec_t;

   vec_t vecs[7];

   dff_rr_ctrl #(.WIDTH(8), .NREQ(4)) dut (
      .clk(clk), .rst(rst), .req(req), .op(op), .din(din),
      .gnt(gnt), .busy(busy), .q(q), .qb(qb), .grant_cnt(grant_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_gnt(output int w);
      w = -1;
      for (int t = 0; t < 10 && w < 0; t++) begin
         @(negedge clk);
         for (int b = 0; b < 4; b++) if (gnt[b]) w = b;
      end
   endtask

   task automatic run_op(input int idx, input logic [1:0] opv, input logic [7:0] dinv,
                         input logic [7:0] exp_q);
      logic [7:0] q0;
      logic [7:0] eqb;
      int n;
      @(negedge clk);
      q0  = q;
      eqb = ~exp_q;
      op  = '0;
      op[2*idx +: 2] = opv;
      din = 32'hC3C3C3C3;
      din[8*idx +: 8] = dinv;
      req = '0;
      req[idx] = 1'b1;
      @(negedge clk);
      chk("issue_busy", busy, 1);
      chk("issue_q_held", q, q0);
      n = 0;
      while (gnt == 4'd0 && n < 8) begin
         @(negedge clk);
         n++;
      end
      chk("gnt_latency", n, 1);
      chk("gnt_value", gnt, 32'd1 << idx);
      chk("op_q", q, exp_q);
      chk("op_qb", qb, eqb);
      req = '0;
      exp_cnt = (exp_cnt + 1) % 256;
      @(negedge clk);
      chk("gnt_one_cycle", gnt, 0);
      chk("grant_cnt", grant_cnt, exp_cnt);
      chk("idle_busy", busy, 0);
   endtask

   initial begin
      int w;
      int seen;
      int pulses;
      int last;
      int bad;
      int cyc;
      int rr_ord[4];
      logic [7:0] rr_din[4];

      vecs[0] = '{2, 2'b00, 8'h3C, 8'h3C};
      vecs[1] = '{1, 2'b10, 8'h00, 8'hFF};
      vecs[2] = '{3, 2'b01, 8'hAA, 8'h00};
      vecs[3] = '{0, 2'b00, 8'h0F, 8'h0F};
      vecs[4] = '{1, 2'b11, 8'h33, EXP_OP11};
      vecs[5] = '{2, 2'b00, 8'h96, 8'h96};
      vecs[6] = '{3, 2'b00, 8'h5A, 8'h5A};
      rr_din  = '{8'h11, 8'h22, 8'h33, 8'h44};

      rst = 1'b0;
      req = '0;
      op  = '0;
      din = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_q", q, 8'h00);
      chk("rst_qb", qb, 8'hFF);
      chk("rst_gnt", gnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cnt", grant_cnt, 0);
      rst = 1'b1;

      for (int i = 0; i < 7; i++) run_op(vecs[i].idx, vecs[i].opv, vecs[i].dinv, vecs[i].exp_q);

      // All four requesting from ptr 0: served 0,1,2,3, each dropping after its gnt.
      @(negedge clk);
      op  = '0;
      din = {rr_din[3], rr_din[2], rr_din[1], rr_din[0]};
      req = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         wait_gnt(w);
         chk("rr4_order", w, k);
         chk("rr4_q", q, rr_din[k]);
         if (w >= 0) req[w] = 1'b0;
         exp_cnt++;
      end

      rr_ord = '{0, 3, 0, 3};
      @(negedge clk);
      req = 4'b1001;
      for (int k = 0; k < 4; k++) begin
         wait_gnt(w);
         chk("rr2_order", w, rr_ord[k]);
         chk("rr2_gnt", gnt, 32'd1 << rr_ord[k]);
         exp_cnt++;
         if (w >= 0) req[w] = 1'b0;
         @(negedge clk);
         if (k < 2 && w >= 0) req[w] = 1'b1;
      end
      chk("rr_cnt", grant_cnt, exp_cnt);

      // Withdraw during ISSUE with op/din scrambled: latched LOAD still completes.
      @(negedge clk);
      op  = '0;
      din = 32'h00007700;
      req = 4'b0010;
      @(negedge clk);
      chk("wd_busy", busy, 1);
      req = '0;
      op  = 8'b0101_0101;
      din = 32'hFFFFFFFF;
      wait_gnt(w);
      chk("wd_gnt", w, 1);
      chk("wd_q", q, 8'h77);
      exp_cnt++;

      run_op(2, 2'b00, 8'hA5, 8'hA5);

      // Reset arriving during ISSUE: immediate clear, no gnt for the aborted op.
      op  = '0;
      din = 32'h00110000;
      req = 4'b0100;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("arst_q", q, 8'h00);
      chk("arst_qb", qb, 8'hFF);
      chk("arst_gnt", gnt, 0);
      chk("arst_busy", busy, 0);
      chk("arst_cnt", grant_cnt, 0);
      req = '0;
      exp_cnt = 0;
      @(negedge clk);
      rst = 1'b1;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (gnt != 4'd0 || q != 8'h00) seen++;
      end
      chk("abort_quiet", seen, 0);

      // Pointer back at 0 after reset, so 1 wins over 3.
      op  = '0;
      din = {rr_din[3], rr_din[2], rr_din[1], rr_din[0]};
      req = 4'b1110;
      wait_gnt(w);
      chk("ptr_rst_win", w, 1);
      chk("ptr_rst_q", q, 8'h22);
      req = '0;
      exp_cnt++;
      @(negedge clk);
      chk("ptr_rst_cnt", grant_cnt, exp_cnt);

      // Held request: back-to-back ops every 3 cycles until grant_cnt wraps.
      req    = 4'b0001;
      pulses = 0;
      last   = -1;
      bad    = 0;
      cyc    = 0;
      while (pulses < 255 && cyc < 1200) begin
         @(negedge clk);
         cyc++;
         if (gnt != 4'd0) begin
            pulses++;
            if (last >= 0 && cyc - last != 3) bad++;
            last = cyc;
            if (pulses == 255) begin
               chk("wrap_cnt_255", grant_cnt, 255);
               req = '0;
            end
         end
      end
      chk("wrap_pulses", pulses, 255);
      chk("wrap_spacing", bad, 0);
      @(negedge clk);
      chk("wrap_cnt_0", grant_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
